// File: rtl/snitch_icache_refill_arbiter.sv
// Shares one L1 refill port among NR_PORTS L0 caches: demand-over-prefetch arbitration, credits, flush sequencing.
// Latency: 0 cycles request path (combinational grant) and 0 cycles response routing.
// Backpressure: a stalled grant is locked until L1 accepts; new grants stop at MAX_OUTSTANDING or while flushing.
module snitch_icache_refill_arbiter #(
  parameter int unsigned NR_PORTS        = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned LINE_WIDTH      = 128,
  parameter int unsigned ID_WIDTH        = $clog2(NR_PORTS) + 1,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned PF_MAX_WAIT     = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_valid_i,
  output logic                           flush_ready_o,
  input  logic [NR_PORTS*ADDR_WIDTH-1:0] in_req_addr_i,
  input  logic [NR_PORTS*ID_WIDTH-1:0]   in_req_id_i,
  input  logic [NR_PORTS-1:0]            in_req_valid_i,
  output logic [NR_PORTS-1:0]            in_req_ready_o,
  output logic [ADDR_WIDTH-1:0]          out_req_addr_o,
  output logic [ID_WIDTH-1:0]            out_req_id_o,
  output logic                           out_req_valid_o,
  input  logic                           out_req_ready_i,
  input  logic [LINE_WIDTH-1:0]          out_rsp_data_i,
  input  logic                           out_rsp_error_i,
  input  logic [ID_WIDTH-1:0]            out_rsp_id_i,
  input  logic                           out_rsp_valid_i,
  output logic                           out_rsp_ready_o,
  output logic [LINE_WIDTH-1:0]          in_rsp_data_o,
  output logic                           in_rsp_error_o,
  output logic [ID_WIDTH-1:0]            in_rsp_id_o,
  output logic [NR_PORTS-1:0]            in_rsp_valid_o,
  input  logic [NR_PORTS-1:0]            in_rsp_ready_i
);

  localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int unsigned AGE_W = $clog2(PF_MAX_WAIT + 1);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  // Per-port request fields, unpacked from the flat port vectors.
  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NR_PORTS-1:0][ID_WIDTH-1:0]   req_id;
  logic [NR_PORTS-1:0]                 dem_vld;
  logic [NR_PORTS-1:0]                 pf_vld;
  logic [NR_PORTS-1:0]                 boost;

  // State
  logic [IDX_W-1:0]                rr_dem_q, rr_dem_d;
  logic [IDX_W-1:0]                rr_pf_q, rr_pf_d;
  logic [NR_PORTS-1:0][AGE_W-1:0]  age_q, age_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [1:0]                      state_q, state_d;
  logic                            lock_q, lock_d;
  logic [IDX_W-1:0]                lock_idx_q, lock_idx_d;
  logic [ADDR_WIDTH-1:0]           lock_addr_q, lock_addr_d;
  logic [ID_WIDTH-1:0]             lock_id_q, lock_id_d;

  // Arbitration and handshake signals
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_allowed;
  logic             req_hs;
  logic             rsp_hs;
  logic [ID_WIDTH-2:0] rsp_port;

  // Port index k positions after base, wrapping at NR_PORTS.
  function automatic logic [IDX_W-1:0] rr_ofs(input logic [IDX_W-1:0] base, input int k);
    rr_ofs = IDX_W'((32'(base) + 32'(k)) % NR_PORTS);
  endfunction

  // Split the flat request vectors and classify each port as demand, prefetch or boosted prefetch.
  always_comb begin
    req_addr = '0;
    req_id   = '0;
    dem_vld  = '0;
    pf_vld   = '0;
    boost    = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      req_addr[i] = in_req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      req_id[i]   = in_req_id_i[i*ID_WIDTH +: ID_WIDTH];
      dem_vld[i]  = in_req_valid_i[i] & ~req_id[i][0];
      pf_vld[i]   = in_req_valid_i[i] &  req_id[i][0];
      boost[i]    = pf_vld[i] && (age_q[i] == AGE_W'(PF_MAX_WAIT));
    end
  end

  // Pick the winner: lowest boosted prefetch, else round-robin demand, else round-robin prefetch.
  // Loops run from the far end down so the last assignment is the highest-priority candidate.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    if (|boost) begin
      for (int i = NR_PORTS - 1; i >= 0; i--) begin
        if (boost[i]) begin
          win_vld = 1'b1;
          win_idx = IDX_W'(i);
        end
      end
    end else if (|dem_vld) begin
      for (int k = NR_PORTS - 1; k >= 0; k--) begin
        if (dem_vld[rr_ofs(rr_dem_q, k)]) begin
          win_vld = 1'b1;
          win_idx = rr_ofs(rr_dem_q, k);
        end
      end
    end else if (|pf_vld) begin
      for (int k = NR_PORTS - 1; k >= 0; k--) begin
        if (pf_vld[rr_ofs(rr_pf_q, k)]) begin
          win_vld = 1'b1;
          win_idx = rr_ofs(rr_pf_q, k);
        end
      end
    end
  end

  // New grants only start when idle, not being asked to flush, and a credit is free.
  assign grant_allowed = (state_q == ST_IDLE) && !flush_valid_i &&
                         (cnt_q != CNT_W'(MAX_OUTSTANDING));

  // Drive the L1 request: a locked grant replays its captured address/ID, otherwise the live winner.
  always_comb begin
    if (lock_q) begin
      grant_idx       = lock_idx_q;
      out_req_addr_o  = lock_addr_q;
      out_req_id_o    = lock_id_q;
      out_req_valid_o = 1'b1;
    end else begin
      grant_idx       = win_idx;
      out_req_addr_o  = req_addr[win_idx];
      out_req_id_o    = req_id[win_idx];
      out_req_valid_o = grant_allowed & win_vld;
    end
  end

  assign req_hs = out_req_valid_o & out_req_ready_i;

  // Only the granted port sees ready, and only in the handshake cycle.
  always_comb begin
    in_req_ready_o = '0;
    if (req_hs) in_req_ready_o[grant_idx] = 1'b1;
  end

  // Capture the grant when L1 stalls so it cannot be pre-empted; release on handshake.
  always_comb begin
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
    lock_addr_d = lock_addr_q;
    lock_id_d   = lock_id_q;
    if (req_hs) begin
      lock_d = 1'b0;
    end else if (out_req_valid_o && !lock_q) begin
      lock_d      = 1'b1;
      lock_idx_d  = grant_idx;
      lock_addr_d = out_req_addr_o;
      lock_id_d   = out_req_id_o;
    end
  end

  // Advance the round-robin pointer of the class that just won.
  always_comb begin
    rr_dem_d = rr_dem_q;
    rr_pf_d  = rr_pf_q;
    if (req_hs) begin
      if (out_req_id_o[0]) rr_pf_d  = rr_ofs(grant_idx, 1);
      else                 rr_dem_d = rr_ofs(grant_idx, 1);
    end
  end

  // Age waiting prefetches; a port resets its age when served or when it stops asking.
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < NR_PORTS; i++) begin
      if (!pf_vld[i] || (req_hs && (grant_idx == IDX_W'(i)))) begin
        age_d[i] = '0;
      end else if (age_q[i] != AGE_W'(PF_MAX_WAIT)) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
    end
  end

  // Response routing: the port index in the ID selects the target; unknown ports are drained.
  assign rsp_port       = out_rsp_id_i[ID_WIDTH-1:1];
  assign in_rsp_data_o  = out_rsp_data_i;
  assign in_rsp_error_o = out_rsp_error_i;
  assign in_rsp_id_o    = out_rsp_id_i;

  // Steer response valid one-hot to the target and take its ready back.
  always_comb begin
    in_rsp_valid_o  = '0;
    out_rsp_ready_o = 1'b1;
    if (32'(rsp_port) < NR_PORTS) begin
      in_rsp_valid_o[rsp_port[IDX_W-1:0]] = out_rsp_valid_i;
      out_rsp_ready_o                     = in_rsp_ready_i[rsp_port[IDX_W-1:0]];
    end
  end

  assign rsp_hs = out_rsp_valid_i & out_rsp_ready_o;

  // In-flight credit counter; clamps at both ends so stray responses after reset are harmless.
  always_comb begin
    cnt_d = cnt_q;
    if (req_hs && !rsp_hs) begin
      if (cnt_q != CNT_W'(MAX_OUTSTANDING)) cnt_d = cnt_q + CNT_W'(1);
    end else if (!req_hs && rsp_hs) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Flush sequencing: block new grants, wait for outstanding refills and any lock, then acknowledge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (flush_valid_i) state_d = ST_DRAIN;
      ST_DRAIN: if ((cnt_q == '0) && !lock_q) state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign flush_ready_o = (state_q == ST_ACK);

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_dem_q    <= '0;
      rr_pf_q     <= '0;
      age_q       <= '0;
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      lock_addr_q <= '0;
      lock_id_q   <= '0;
    end else begin
      rr_dem_q    <= rr_dem_d;
      rr_pf_q     <= rr_pf_d;
      age_q       <= age_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      lock_addr_q <= lock_addr_d;
      lock_id_q   <= lock_id_d;
    end
  end

endmodule

// File: doc/snitch_icache_refill_arbiter.md
Name: snitch_icache_refill_arbiter

Overview:
- Shares the single L1 refill port among NR_PORTS private L0 line caches.
- Arbitrates refill and prefetch requests. Demand refills have priority over prefetches, with round-robin inside each class and an anti-starvation boost for aged prefetches.
- Bounds in-flight refills and routes responses back by ID.
- Sequences cache flushes: new requests are blocked, in-flight refills drain, then the flush is acknowledged.

Parameters:
- NR_PORTS, 4, number of L0 requesters (>=2).
- ADDR_WIDTH, 32, fetch address width.
- LINE_WIDTH, 128, refill data width.
- ID_WIDTH, $clog2(NR_PORTS)+1, request/response ID width. Format is {port_idx, is_prefetch}.
- MAX_OUTSTANDING, 4, maximum in-flight refills (>=1).
- PF_MAX_WAIT, 8, cycles a prefetch may lose arbitration before it is boosted (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_valid_i  in  1  flush request, held until flush_ready_o.
- flush_ready_o  out  1  flush acknowledge, one-cycle pulse.
- in_req_addr_i  in  NR_PORTS*ADDR_WIDTH  per-port line address.
- in_req_id_i  in  NR_PORTS*ID_WIDTH  per-port ID. Bit 0 is is_prefetch.
- in_req_valid_i  in  NR_PORTS  per-port request valid.
- in_req_ready_o  out  NR_PORTS  per-port request ready.
- out_req_addr_o  out  ADDR_WIDTH  granted address.
- out_req_id_o  out  ID_WIDTH  granted ID, passed through unchanged.
- out_req_valid_o  out  1  request to L1.
- out_req_ready_i  in  1  L1 accepts request.
- out_rsp_data_i  in  LINE_WIDTH  refill line.
- out_rsp_error_i  in  1  refill error.
- out_rsp_id_i  in  ID_WIDTH  response ID.
- out_rsp_valid_i  in  1  response valid.
- out_rsp_ready_o  out  1  response accept.
- in_rsp_data_o  out  LINE_WIDTH  broadcast to all ports.
- in_rsp_error_o  out  1  broadcast to all ports.
- in_rsp_id_o  out  ID_WIDTH  broadcast to all ports.
- in_rsp_valid_o  out  NR_PORTS  one-hot to the target port.
- in_rsp_ready_i  in  NR_PORTS  per-port response ready.

Behaviour:
- Reset values: out_req_valid_o=0, in_req_ready_o=0, flush_ready_o=0, in-flight count=0, RR pointers=0, age counters=0, FSM=IDLE, no grant locked.
- Classes: demand is valid with id[0]=0; prefetch is valid with id[0]=1.
- Winner selection:
  - Any boosted prefetch wins; the lowest-index boosted prefetch first.
  - Otherwise any demand request wins, round-robin from rr_dem_q.
  - Otherwise any prefetch wins, round-robin from rr_pf_q.
- The winner drives out_req_* combinationally. Latency is 0 cycles from in_req_valid_i to out_req_valid_o.
- Lock: if out_req_valid_o=1 and out_req_ready_i=0, the grant index is registered and held. Address, ID and valid stay stable until the handshake, regardless of new higher-priority requests or flush.
- Requester handshake: in_req_ready_o[g] = out_req_ready_i & out_req_valid_o for grant g; all other ready bits are 0.
- RR update: on handshake, the pointer of the granted class becomes g+1 mod NR_PORTS.
- Aging:
  - Per-port age counter, width $clog2(PF_MAX_WAIT+1).
  - Increments, saturating, each cycle a port presents a prefetch and is not handshaked.
  - Clears on that port's handshake or when its valid drops.
  - A port is boosted when its age == PF_MAX_WAIT.
- Credit limit:
  - Counter cnt in range 0..MAX_OUTSTANDING.
  - +1 on request handshake; -1 on response handshake (out_rsp_valid_i & out_rsp_ready_o).
  - Simultaneous increment and decrement leaves cnt unchanged.
  - A new grant is not started while cnt==MAX_OUTSTANDING; out_req_valid_o=0. A locked grant is unaffected.
  - If cnt==MAX_OUTSTANDING and a response and a locked-grant handshake occur in the same cycle, cnt stays at MAX_OUTSTANDING.
- Response routing:
  - p = out_rsp_id_i[ID_WIDTH-1:1].
  - in_rsp_valid_o[p] = out_rsp_valid_i; out_rsp_ready_o = in_rsp_ready_i[p].
  - If p >= NR_PORTS: out_rsp_ready_o=1, the response is discarded, and cnt still decrements.
- Flush FSM:
  - IDLE -> DRAIN on flush_valid_i. In DRAIN, no new grant is started; a locked grant still completes.
  - DRAIN -> ACK when cnt==0 and no lock is held.
  - ACK: flush_ready_o=1 for one cycle, then -> IDLE.
  - If flush_valid_i is already 0 at ACK, still return to IDLE.
  - IDLE with cnt==0, no lock and flush_valid_i: DRAIN->ACK takes 1 cycle, so acknowledge comes 2 cycles after the request.
- Reset mid-operation clears all state. In-flight responses arriving after reset are routed normally; cnt saturates at 0 on decrement.

Test Plan:
- Ports 0 and 2 demand simultaneously, ready=1, rr=0 -> grant 0 in cycle 0, grant 2 in cycle 1; rr_dem_q=3.
- Port 1 prefetch and port 3 demand together -> port 3 granted. Port 1 wins once port 3 drops, or after 8 losing cycles becomes boosted and wins on cycle 9.
- out_req_ready_i=0 for 5 cycles with port 1 locked, then port 0 demand arrives -> addr/ID of port 1 stable for all 5 cycles; port 0 granted after the port 1 handshake.
- MAX_OUTSTANDING=4, issue 4 requests with no responses -> 5th is held with out_req_valid_o=0. One response to ID {2,0} -> in_rsp_valid_o=4'b0100, cnt=3, 5th request issues next cycle.
- Simultaneous request handshake and response at cnt=2 -> cnt stays 2.
- Flush with cnt=2 -> no new grants. flush_ready_o pulses 1 cycle after the second response drains; FSM returns to IDLE.
